// File: rtl/hack_mem_pkg.sv
// Shared memory-map constants and region decode for the Hack data memory.
package hack_mem_pkg;

    localparam logic [14:0] RAM_BASE    = 15'h0000;
    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;
    localparam int unsigned RAM_WORDS   = 16384;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_SCREEN,
        REGION_KBD,
        REGION_NONE
    } region_t;

    // RAM and screen are selected by their high address bits; KBD is one word.
    function automatic region_t decode_region(input logic [14:0] addr);
        region_t region;
        if (addr[14] == RAM_BASE[14])
            region = REGION_RAM;
        else if (addr[14:13] == SCREEN_BASE[14:13])
            region = REGION_SCREEN;
        else if (addr == KBD_ADDR)
            region = REGION_KBD;
        else
            region = REGION_NONE;
        return region;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard scancode queue: DEPTH-entry FIFO with KBD_FIFO_EN defined,
// otherwise a single overwrite-on-push holding register.
module kbd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push_valid,
    input  logic [15:0] i_push_data,
    input  logic        i_pop,
    output logic        o_ready,
    output logic [4:0]  o_count,
    output logic [15:0] o_head
);

`ifdef KBD_FIFO_EN
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam logic [4:0]  FULL_COUNT = 5'(DEPTH);

    logic [15:0]      r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [4:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // Ready depends on current occupancy only, so a full queue refuses a
    // push even when the same cycle pops.
    assign o_ready = (r_count != FULL_COUNT);
    assign w_push  = i_push_valid && o_ready;
    assign w_pop   = i_pop && (r_count != 5'd0);
    assign o_count = r_count;
    assign o_head  = (r_count != 5'd0) ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset && w_push)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    // Single-entry capacity regardless of DEPTH.
    localparam logic [4:0] HOLD_MAX = (DEPTH >= 1) ? 5'd1 : 5'd0;

    logic [15:0] r_hold;
    logic        r_full;

    assign o_ready = 1'b1;
    assign o_count = r_full ? HOLD_MAX : '0;
    assign o_head  = r_hold;

    // A push in the same cycle as a pop wins: the new scancode is kept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else if (i_push_valid) begin
            r_hold <= i_push_data;
            r_full <= 1'b1;
        end else if (i_pop) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/data_memory.sv
// Hack data memory: 16K RAM, screen buffer with scanner port, keyboard queue.
// Define KBD_FIFO_EN for the multi-entry keyboard FIFO.
module data_memory #(
    parameter int unsigned KBD_DEPTH    = 4,
    parameter int unsigned SCREEN_WORDS = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic        writeM,
    input  logic [15:0] outM,
    output logic [15:0] inM,
    input  logic [12:0] screen_addr,
    output logic [15:0] screen_data,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_data,
    output logic        kbd_ready,
    output logic [4:0]  kbd_count
);
    import hack_mem_pkg::*;

    logic [15:0] r_ram    [0:RAM_WORDS-1];
    logic [15:0] r_screen [0:SCREEN_WORDS-1];
    logic [15:0] r_inM;
    logic [15:0] r_screen_data;
    region_t     w_region;
    logic        w_wr_en;
    logic        w_kbd_pop;
    logic [15:0] w_kbd_head;
    logic [15:0] w_rd_data;

    assign w_region  = decode_region(addressM);
    assign w_wr_en   = reset && writeM;
    assign w_kbd_pop = w_wr_en && (w_region == REGION_KBD);

    kbd_fifo #(
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push_valid (kbd_valid),
        .i_push_data  (kbd_data),
        .i_pop        (w_kbd_pop),
        .o_ready      (kbd_ready),
        .o_count      (kbd_count),
        .o_head       (w_kbd_head)
    );

    // Array contents survive reset; only the write enable is gated by it.
    always_ff @(posedge clk) begin
        if (w_wr_en && (w_region == REGION_RAM))
            r_ram[addressM[13:0]] <= outM;
        if (w_wr_en && (w_region == REGION_SCREEN))
            r_screen[addressM[12:0]] <= outM;
    end

    always_comb begin
        w_rd_data = '0;
        case (w_region)
            REGION_RAM:    w_rd_data = r_ram[addressM[13:0]];
            REGION_SCREEN: w_rd_data = r_screen[addressM[12:0]];
            REGION_KBD:    w_rd_data = w_kbd_head;
            default:       w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_inM         <= '0;
            r_screen_data <= '0;
        end else begin
            r_inM         <= w_rd_data;
            r_screen_data <= r_screen[screen_addr];
        end
    end

    assign inM         = r_inM;
    assign screen_data = r_screen_data;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (both keyboard queue forms).
module tb_data_memory;

`ifdef KBD_FIFO_EN
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam bit FIFO_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] addressM;
    logic        writeM;
    logic [15:0] outM;
    logic [15:0] inM;
    logic [12:0] screen_addr;
    logic [15:0] screen_data;
    logic        kbd_valid;
    logic [15:0] kbd_data;
    logic        kbd_ready;
    logic [4:0]  kbd_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    data_memory #(
        .KBD_DEPTH    (4),
        .SCREEN_WORDS (8192)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addressM    (addressM),
        .writeM      (writeM),
        .outM        (outM),
        .inM         (inM),
        .screen_addr (screen_addr),
        .screen_data (screen_data),
        .kbd_valid   (kbd_valid),
        .kbd_data    (kbd_data),
        .kbd_ready   (kbd_ready),
        .kbd_count   (kbd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    endtask

    // Apply one cycle of CPU/keyboard inputs, then sample 1 time unit after the edge.
    task automatic step(input logic [14:0] a, input logic we, input logic [15:0] d,
                        input logic kv, input logic [15:0] kd);
        addressM  = a;
        writeM    = we;
        outM      = d;
        kbd_valid = kv;
        kbd_data  = kd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        addressM    = '0;
        writeM      = 1'b0;
        outM        = '0;
        screen_addr = '0;
        kbd_valid   = 1'b0;
        kbd_data    = '0;

        step(15'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        step(15'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("rst_inM", inM, 16'h0000);
        check("rst_screen", screen_data, 16'h0000);
        check("rst_count", {11'd0, kbd_count}, 16'd0);
        check("rst_ready", {15'd0, kbd_ready}, 16'd1);
        reset = 1'b1;

        // Write then read back with one-cycle latency
        step(15'h0010, 1'b1, 16'h1234, 1'b0, 16'h0000);
        step(15'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("ram_rd", inM, 16'h1234);

        // Read-first on a same-cycle write
        step(15'h0020, 1'b1, 16'h0000, 1'b0, 16'h0000);
        step(15'h0020, 1'b1, 16'hBEEF, 1'b0, 16'h0000);
        check("ram_rdfirst_old", inM, 16'h0000);
        step(15'h0020, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("ram_rdfirst_new", inM, 16'hBEEF);

        // Top RAM word must not alias into the screen
        step(15'h3FFF, 1'b1, 16'h5A5A, 1'b0, 16'h0000);
        step(15'h3FFF, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("ram_top", inM, 16'h5A5A);

        // Screen via CPU port and scanner port
        step(15'h4005, 1'b1, 16'hFFFF, 1'b0, 16'h0000);
        screen_addr = 13'd5;
        step(15'h4005, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("scr_port", screen_data, 16'hFFFF);
        check("scr_cpu", inM, 16'hFFFF);
        step(15'h4006, 1'b1, 16'h0000, 1'b0, 16'h0000);
        screen_addr = 13'd6;
        step(15'h4006, 1'b1, 16'hAAAA, 1'b0, 16'h0000);
        check("scr_rdfirst_old", screen_data, 16'h0000);
        step(15'h4006, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("scr_rdfirst_new", screen_data, 16'hAAAA);

        // Unmapped reads return zero, writes there are dropped
        step(15'h7000, 1'b1, 16'h1111, 1'b0, 16'h0000);
        step(15'h7000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("unmapped_7000", inM, 16'h0000);
        step(15'h6001, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("unmapped_6001", inM, 16'h0000);

        // Fill keyboard queue
        step(15'h0000, 1'b0, 16'h0000, 1'b1, 16'h0041);
        step(15'h0000, 1'b0, 16'h0000, 1'b1, 16'h0042);
        step(15'h0000, 1'b0, 16'h0000, 1'b1, 16'h0043);
        step(15'h0000, 1'b0, 16'h0000, 1'b1, 16'h0044);
        check("kbd_full_count", {11'd0, kbd_count}, FIFO_MODE ? 16'd4 : 16'd1);
        check("kbd_full_ready", {15'd0, kbd_ready}, FIFO_MODE ? 16'd0 : 16'd1);

        // Push while full plus pop-and-read
        step(15'h6000, 1'b1, 16'h9999, 1'b1, 16'h0045);
        check("kbd_prepop_head", inM, FIFO_MODE ? 16'h0041 : 16'h0044);
        check("kbd_full_pushpop", {11'd0, kbd_count}, FIFO_MODE ? 16'd3 : 16'd1);
        step(15'h6000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("kbd_head_after", inM, FIFO_MODE ? 16'h0042 : 16'h0045);

        step(15'h6000, 1'b1, 16'h0000, 1'b0, 16'h0000);
        check("kbd_pop_inM", inM, FIFO_MODE ? 16'h0042 : 16'h0045);
        check("kbd_pop_count", {11'd0, kbd_count}, FIFO_MODE ? 16'd2 : 16'd0);

        // Simultaneous push and pop
        step(15'h6000, 1'b1, 16'h0000, 1'b1, 16'h0041);
        check("kbd_pushpop_inM", inM, FIFO_MODE ? 16'h0043 : 16'h0000);
        check("kbd_pushpop_count", {11'd0, kbd_count}, FIFO_MODE ? 16'd2 : 16'd1);
        step(15'h6000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("kbd_pushpop_head", inM, FIFO_MODE ? 16'h0044 : 16'h0041);

        // Drain past the pointer wrap, then pop while empty
        step(15'h6000, 1'b1, 16'h0000, 1'b0, 16'h0000);
        check("kbd_drain1", inM, FIFO_MODE ? 16'h0044 : 16'h0041);
        step(15'h6000, 1'b1, 16'h0000, 1'b0, 16'h0000);
        check("kbd_drain2", inM, FIFO_MODE ? 16'h0041 : 16'h0000);
        check("kbd_drain_count", {11'd0, kbd_count}, 16'd0);
        step(15'h6000, 1'b1, 16'h0000, 1'b0, 16'h0000);
        check("kbd_empty_pop_count", {11'd0, kbd_count}, 16'd0);
        step(15'h6000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("kbd_empty_read", inM, 16'h0000);

        // Reset mid-operation discards the queue and blocks writes/pushes
        step(15'h0000, 1'b0, 16'h0000, 1'b1, 16'h0051);
        step(15'h0000, 1'b0, 16'h0000, 1'b1, 16'h0052);
        step(15'h0010, 1'b0, 16'h0000, 1'b1, 16'h0053);
        check("kbd_pre_rst_count", {11'd0, kbd_count}, FIFO_MODE ? 16'd3 : 16'd1);
        check("kbd_pre_rst_inM", inM, 16'h1234);
        reset = 1'b0;
        step(15'h0010, 1'b1, 16'hDEAD, 1'b1, 16'h0054);
        check("rst2_count", {11'd0, kbd_count}, 16'd0);
        check("rst2_inM", inM, 16'h0000);
        check("rst2_ready", {15'd0, kbd_ready}, 16'd1);
        check("rst2_screen", screen_data, 16'h0000);
        reset = 1'b1;
        step(15'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("ram_kept", inM, 16'h1234);
        step(15'h6000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("kbd_after_rst", inM, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
